// File: rtl/aes_ctr_ctrl.sv
// aes_ctr_ctrl: CTR-mode controller around an AES core; builds counter blocks,
// launches one encryption per data block and XORs the keystream into the data.
module aes_ctr_ctrl #(
    parameter int CTR_W       = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] iv_i,
    input  logic         iv_load_i,
    input  logic [127:0] data_i,
    input  logic         data_valid_i,
    output logic         data_ready_o,
    output logic [127:0] ctr_block_o,
    output logic         core_start_o,
    input  logic [127:0] keystream_i,
    input  logic         keystream_valid_i,
    output logic [127:0] data_o,
    output logic         data_valid_o,
    input  logic         data_ready_i,
    output logic         wrap_o,
    output logic         err_o
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] READY  = 3'd1;
    localparam logic [2:0] LAUNCH = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] OUT    = 3'd4;
    localparam logic [2:0] LOCKED = 3'd5;
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]       state;
    logic [127:0]     data_buf;
    logic [WD_W-1:0]  wdog;
    logic [CTR_W-1:0] ctr_next;
    logic             ctr_full;
    logic             load;

    assign load         = iv_load_i && (state == IDLE || state == READY || state == LOCKED);
    assign ctr_next     = ctr_block_o[CTR_W-1:0] + CTR_W'(1);
    assign ctr_full     = &ctr_block_o[CTR_W-1:0];
    assign data_ready_o = state == READY;
    assign core_start_o = state == LAUNCH;
    assign data_valid_o = state == OUT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ctr_block_o <= '0;
            data_buf    <= '0;
            data_o      <= '0;
            wdog        <= '0;
            wrap_o      <= 1'b0;
            err_o       <= 1'b0;
        end else if (load) begin
            // an IV load outranks a simultaneous data_valid_i in READY
            ctr_block_o <= iv_i;
            wrap_o      <= 1'b0;
            err_o       <= 1'b0;
            state       <= READY;
        end else begin
            case (state)
                READY: if (data_valid_i) begin
                    data_buf <= data_i;
                    state    <= LAUNCH;
                end
                LAUNCH: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: if (keystream_valid_i) begin
                    data_o <= data_buf ^ keystream_i;
                    state  <= OUT;
                end else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
                    err_o <= 1'b1;
                    state <= LOCKED;
                end else begin
                    wdog <= wdog + WD_W'(1);
                end
                OUT: if (data_ready_i) begin
                    // counter field wraps without carrying into the nonce
                    ctr_block_o <= {ctr_block_o[127:CTR_W], ctr_next};
                    wrap_o      <= ctr_full;
                    state       <= ctr_full ? LOCKED : READY;
                end
                IDLE, LOCKED: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
